// File: rtl/cpu_pipe_pkg.sv
// Shared constants and width helpers for the per-CPU pipeline state tracker.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cpu_pipe_pkg;

    // Defaults matching the sha512crypt task CPU build.
    localparam int N_STAGES_DEF  = 4;
    localparam int N_THREADS_DEF = 16;

    // Stage encoding used by fetch/decode/execute.
    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        READ0  = 2'd1,
        DECODE = 2'd2,
        EXEC   = 2'd3
    } stage_e;

    // Thread tag width; a single-thread CPU still carries a 1-bit tag.
    function automatic int tw_f(input int n_threads);
        return (n_threads > 1) ? $clog2(n_threads) : 1;
    endfunction

    // Stage index width used by kill_stage.
    function automatic int siw_f(input int n_stages);
        return (n_stages > 1) ? $clog2(n_stages) : 1;
    endfunction

endpackage

// File: rtl/cpu_pipe_slot.sv
// One pipeline stage: reached bit, thread tag and registered execute-enable.
// Latency: one edge from src_vld to reached_q/allow_q.
// Backpressure: instr_wait freezes non-first slots; the first slot still takes src_vld.
module cpu_pipe_slot
    import cpu_pipe_pkg::*;
#(
    parameter int TW       = 4,
    parameter bit IS_FIRST = 1'b0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          instr_wait,
    input  logic          src_vld,
    input  logic [TW-1:0] src_tag,
    output logic          reached_q,
    output logic [TW-1:0] tag_q,
    output logic          allow_q
);

    logic          reached_d;
    logic          allow_d;
    logic          adv;
    logic [TW-1:0] tag_d;

    // Next state: the first slot is sticky and ignores the stall; later slots shift or hold.
    always_comb begin
        adv       = 1'b0;
        reached_d = reached_q;
        allow_d   = 1'b0;
        tag_d     = tag_q;
        if (IS_FIRST) begin
            adv       = src_vld & ~clr;
            reached_d = ~clr & (src_vld | reached_q);
            allow_d   = ~clr & ~instr_wait & (src_vld | reached_q);
        end else begin
            adv       = ~clr & ~instr_wait;
            reached_d = clr ? 1'b0 : (instr_wait ? reached_q : src_vld);
            allow_d   = adv & src_vld;
        end
        if (adv) begin
            tag_d = src_tag;
        end
    end

    // Stage registers; tags are only cleared by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reached_q <= 1'b0;
            tag_q     <= '0;
            allow_q   <= 1'b0;
        end else begin
            reached_q <= reached_d;
            tag_q     <= tag_d;
            allow_q   <= allow_d;
        end
    end

endmodule

// File: rtl/cpu_pipe_state.sv
// Pipeline occupancy and thread-tag tracker for a multi-threaded task CPU.
// Latency: reload -> stage_allow[i] after 1+i edges; busy/switch flags lag reached by one edge.
// Backpressure: instr_wait stalls stages 1..N-1; stage 0 still accepts reload.
module cpu_pipe_state
    import cpu_pipe_pkg::*;
#(
    parameter  int N_STAGES     = N_STAGES_DEF,
    parameter  int N_THREADS    = N_THREADS_DEF,
    // SWITCH_STAGE+1 must be a valid stage index.
    parameter  int SWITCH_STAGE = int'(READ0),
    localparam int TW           = tw_f(N_THREADS),
    localparam int SIW          = siw_f(N_STAGES)
) (
    input  logic                   CLK,
    input  logic                   RESETn,
    input  logic                   invalidate,
    input  logic                   kill_en,
    input  logic [SIW-1:0]         kill_stage,
    input  logic                   instr_wait,
    input  logic                   reload,
    input  logic [TW-1:0]          reload_thread,
    output logic [N_STAGES-1:0]    stage_allow,
    output logic [N_STAGES*TW-1:0] stage_thread,
    output logic                   thread_almost_switched,
    output logic [N_THREADS-1:0]   thread_busy,
    output logic                   pipe_empty
);

    logic [N_STAGES-1:0]    reached;
    logic [N_STAGES-1:0]    allow;
    logic [N_STAGES-1:0]    clr;
    logic [N_STAGES-1:0]    src_vld;
    logic [N_STAGES*TW-1:0] tag_flat;
    logic [N_STAGES*TW-1:0] src_tag_flat;

    logic                   tas_d;
    logic                   tas_q;
    logic [N_THREADS-1:0]   busy_d;
    logic [N_THREADS-1:0]   busy_q;

    // Slot chain: slot 0 is fed by the scheduler reload, slot i by slot i-1.
    for (genvar i = 0; i < N_STAGES; i++) begin : g_slot
        // A kill clears its start stage and everything behind it; out-of-range values clear nothing.
        assign clr[i] = invalidate | (kill_en & (kill_stage <= SIW'(i)));

        if (i == 0) begin : g_src_reload
            assign src_vld[i]               = reload;
            assign src_tag_flat[i*TW +: TW] = reload_thread;
        end else begin : g_src_prev
            assign src_vld[i]               = reached[i-1];
            assign src_tag_flat[i*TW +: TW] = tag_flat[(i-1)*TW +: TW];
        end

        cpu_pipe_slot #(
            .TW       (TW),
            .IS_FIRST (i == 0)
        ) u_slot (
            .clk        (CLK),
            .rst_n      (RESETn),
            .clr        (clr[i]),
            .instr_wait (instr_wait),
            .src_vld    (src_vld[i]),
            .src_tag    (src_tag_flat[i*TW +: TW]),
            .reached_q  (reached[i]),
            .tag_q      (tag_flat[i*TW +: TW]),
            .allow_q    (allow[i])
        );
    end

    // Switch notify and per-thread busy, both derived from the current stage registers.
    always_comb begin
        tas_d  = reached[SWITCH_STAGE] & ~reached[SWITCH_STAGE+1];
        busy_d = '0;
        for (int t = 0; t < N_THREADS; t++) begin
            for (int i = 0; i < N_STAGES; i++) begin
                if (reached[i] && (tag_flat[i*TW +: TW] == TW'(t))) begin
                    busy_d[t] = 1'b1;
                end
            end
        end
    end

    // Registered status flags.
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            tas_q  <= 1'b0;
            busy_q <= '0;
        end else begin
            tas_q  <= tas_d;
            busy_q <= busy_d;
        end
    end

    assign stage_allow            = allow;
    assign stage_thread           = tag_flat;
    assign thread_almost_switched = tas_q;
    assign thread_busy            = busy_q;
    assign pipe_empty             = ~|reached;

endmodule

// File: tb/tb_cpu_pipe_state.sv
// Directed bench for cpu_pipe_state with a queue-based scoreboard.
// Latency: expectations are pushed after each active edge and checked on the falling edge.
// Backpressure: n/a (bench).
module tb_cpu_pipe_state;

    logic        CLK = 1'b0;
    logic        RESETn = 1'b0;
    logic        invalidate = 1'b0;
    logic        kill_en = 1'b0;
    logic [1:0]  kill_stage = 2'd0;
    logic        instr_wait = 1'b0;
    logic        reload = 1'b0;
    logic [3:0]  reload_thread = 4'd0;
    logic [3:0]  stage_allow;
    logic [15:0] stage_thread;
    logic        thread_almost_switched;
    logic [15:0] thread_busy;
    logic        pipe_empty;

    typedef struct {
        logic [3:0]  allow;
        logic [15:0] thr;
        logic        tas;
        logic [15:0] busy;
        logic        empty;
        string       nm;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    event sample_ev;

    cpu_pipe_state #(
        .N_STAGES     (4),
        .N_THREADS    (16),
        .SWITCH_STAGE (1)
    ) dut (
        .CLK                    (CLK),
        .RESETn                 (RESETn),
        .invalidate             (invalidate),
        .kill_en                (kill_en),
        .kill_stage             (kill_stage),
        .instr_wait             (instr_wait),
        .reload                 (reload),
        .reload_thread          (reload_thread),
        .stage_allow            (stage_allow),
        .stage_thread           (stage_thread),
        .thread_almost_switched (thread_almost_switched),
        .thread_busy            (thread_busy),
        .pipe_empty             (pipe_empty)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string nm, input string fld, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s %s got %h want %h", nm, fld, got, exp);
        end
    endtask

    // Monitor: pops one expectation per falling edge (or on an explicit sample) and compares.
    initial begin : mon
        exp_t e;
        forever begin
            @(negedge CLK or sample_ev);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk(e.nm, "stage_allow", {12'd0, stage_allow}, {12'd0, e.allow});
                chk(e.nm, "stage_thread", stage_thread, e.thr);
                chk(e.nm, "almost_switched", {15'd0, thread_almost_switched}, {15'd0, e.tas});
                chk(e.nm, "thread_busy", thread_busy, e.busy);
                chk(e.nm, "pipe_empty", {15'd0, pipe_empty}, {15'd0, e.empty});
            end
        end
    end

    task automatic push(input logic [3:0] ea, input logic [15:0] eth, input logic et,
                        input logic [15:0] eb, input logic ee, input string nm);
        exp_t e;
        e.allow = ea;
        e.thr   = eth;
        e.tas   = et;
        e.busy  = eb;
        e.empty = ee;
        e.nm    = nm;
        sb.push_back(e);
    endtask

    // Drive one cycle of inputs, then queue the expected outputs after the edge.
    task automatic cyc(input logic inv, input logic kil, input logic [1:0] ks, input logic wt,
                       input logic rl, input logic [3:0] rt,
                       input logic [3:0] ea, input logic [15:0] eth, input logic et,
                       input logic [15:0] eb, input logic ee, input string nm);
        invalidate    = inv;
        kill_en       = kil;
        kill_stage    = ks;
        instr_wait    = wt;
        reload        = rl;
        reload_thread = rt;
        @(posedge CLK);
        #1;
        push(ea, eth, et, eb, ee, nm);
    endtask

    task automatic idle(input logic [3:0] ea, input logic [15:0] eth, input logic et,
                        input logic [15:0] eb, input logic ee, input string nm);
        cyc(1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 4'd0, ea, eth, et, eb, ee, nm);
    endtask

    // Fill from empty with all tags at zero.
    task automatic do_fill(input string pfx);
        cyc(1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 4'd5, 4'b0001, 16'h0005, 1'b0, 16'h0000, 1'b0, {pfx, "_1"});
        idle(4'b0011, 16'h0055, 1'b0, 16'h0020, 1'b0, {pfx, "_2"});
        idle(4'b0111, 16'h0555, 1'b1, 16'h0020, 1'b0, {pfx, "_3"});
        idle(4'b1111, 16'h5555, 1'b0, 16'h0020, 1'b0, {pfx, "_4"});
    endtask

    // Drop reset between edges; outputs must clear before the next clock.
    task automatic async_reset();
        @(negedge CLK);
        #2;
        RESETn = 1'b0;
        #1;
        push(4'b0000, 16'h0000, 1'b0, 16'h0000, 1'b1, "async_rst");
        -> sample_ev;
        @(posedge CLK);
        #1;
        push(4'b0000, 16'h0000, 1'b0, 16'h0000, 1'b1, "rst_hold");
        RESETn = 1'b1;
    endtask

    initial begin
        // Reset held through an edge, then released.
        idle(4'b0000, 16'h0000, 1'b0, 16'h0000, 1'b1, "reset");
        RESETn = 1'b1;
        idle(4'b0000, 16'h0000, 1'b0, 16'h0000, 1'b1, "idle");

        // Fill with thread 5.
        do_fill("fill");
        idle(4'b1111, 16'h5555, 1'b0, 16'h0020, 1'b0, "full");

        // Three-cycle stall, then resume.
        for (int k = 0; k < 3; k++) begin
            cyc(1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 4'd0, 4'b0000, 16'h5555, 1'b0, 16'h0020, 1'b0, "stall");
        end
        idle(4'b1111, 16'h5555, 1'b0, 16'h0020, 1'b0, "stall_release");

        // Kill from stage 2, refill two edges later with a fresh switch pulse.
        cyc(1'b0, 1'b1, 2'd2, 1'b0, 1'b0, 4'd0, 4'b0011, 16'h5555, 1'b0, 16'h0020, 1'b0, "kill2");
        idle(4'b0111, 16'h5555, 1'b1, 16'h0020, 1'b0, "kill2_r1");
        idle(4'b1111, 16'h5555, 1'b0, 16'h0020, 1'b0, "kill2_r2");

        // Kill from stage 0 discards a simultaneous reload.
        cyc(1'b0, 1'b1, 2'd0, 1'b0, 1'b1, 4'd9, 4'b0000, 16'h5555, 1'b0, 16'h0020, 1'b1, "kill0_rld");
        idle(4'b0000, 16'h5555, 1'b0, 16'h0000, 1'b1, "kill0_after");

        // Reload of thread 3 accepted during a stall, then fill.
        cyc(1'b0, 1'b0, 2'd0, 1'b1, 1'b1, 4'd3, 4'b0000, 16'h5553, 1'b0, 16'h0000, 1'b0, "rld_wait");
        idle(4'b0011, 16'h5533, 1'b0, 16'h0008, 1'b0, "t3_2");
        idle(4'b0111, 16'h5333, 1'b1, 16'h0008, 1'b0, "t3_3");
        idle(4'b1111, 16'h3333, 1'b0, 16'h0008, 1'b0, "t3_4");

        // Thread switch: invalidate, reload thread 7.
        cyc(1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 4'd0, 4'b0000, 16'h3333, 1'b0, 16'h0008, 1'b1, "sw_inv");
        cyc(1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 4'd7, 4'b0001, 16'h3337, 1'b0, 16'h0000, 1'b0, "sw_rld");
        idle(4'b0011, 16'h3377, 1'b0, 16'h0080, 1'b0, "sw_2");
        idle(4'b0111, 16'h3777, 1'b1, 16'h0080, 1'b0, "sw_3");
        idle(4'b1111, 16'h7777, 1'b0, 16'h0080, 1'b0, "sw_4");

        // Kill of the last stage during a stall: unkilled stages hold.
        cyc(1'b0, 1'b1, 2'd3, 1'b1, 1'b0, 4'd0, 4'b0000, 16'h7777, 1'b0, 16'h0080, 1'b0, "kill3_wait");
        idle(4'b1111, 16'h7777, 1'b0, 16'h0080, 1'b0, "kill3_refill");

        // Invalidate dominates reload, kill and stall together.
        cyc(1'b1, 1'b1, 2'd3, 1'b1, 1'b1, 4'd9, 4'b0000, 16'h7777, 1'b0, 16'h0080, 1'b1, "inv_rld");
        idle(4'b0000, 16'h7777, 1'b0, 16'h0000, 1'b1, "inv_rld_2");

        // Partial fill with thread 10, then asynchronous reset.
        cyc(1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 4'd10, 4'b0001, 16'h777A, 1'b0, 16'h0000, 1'b0, "rld_a1");
        idle(4'b0011, 16'h77AA, 1'b0, 16'h0400, 1'b0, "rld_a2");
        async_reset();

        // Fill after reset behaves as from empty.
        do_fill("refill");
        idle(4'b1111, 16'h5555, 1'b0, 16'h0020, 1'b0, "refull");

        @(negedge CLK);
        #1;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain left %0d want 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cpu_pipe_state.md
Name: cpu_pipe_state

Overview:
- Per-CPU pipeline occupancy and thread-tag tracker for the multi-threaded sha512crypt task CPU.
- Generalises the single-thread stage tracker: parametrised stage count, thread count and switch-notify stage.
- Adds stall-hold, partial kill from a given stage, per-stage thread tags and per-thread busy flags.
- Sits between the thread scheduler (reload/invalidate) and the instruction fetch/decode/execute stages, which consume stage_allow and stage_thread.

Parameters:
- N_STAGES, 4: pipeline stages tracked; range 3..16.
- N_THREADS, 16: threads per CPU; TW = max(1, clog2(N_THREADS)).
- SWITCH_STAGE, 1: stage whose leading edge raises thread_almost_switched; requires SWITCH_STAGE+1 < N_STAGES.

Ports:
- CLK  in  1  clock; all state changes on rising edge.
- RESETn  in  1  asynchronous, active-low reset.
- invalidate  in  1  flush the whole pipeline.
- kill_en  in  1  partial flush request.
- kill_stage  in  clog2(N_STAGES)  first stage cleared by kill_en.
- instr_wait  in  1  stall; no movement through stages 1..N-1.
- reload  in  1  load a new thread into stage 0.
- reload_thread  in  TW  thread number for reload.
- stage_allow  out  N_STAGES  per-stage execute enable (registered).
- stage_thread  out  N_STAGES*TW  tag of each stage; stage i occupies bits [i*TW +: TW].
- thread_almost_switched  out  1  registered switch notification.
- thread_busy  out  N_THREADS  thread t has at least one valid stage (registered).
- pipe_empty  out  1  no stage reached.

Behaviour:
- Reset (RESETn=0, asynchronous): stage_reached=0, all tags=0, stage_allow=0, thread_almost_switched=0, thread_busy=0; pipe_empty=1.
- Internal stage_reached[N_STAGES]. pipe_empty = ~|stage_reached, combinational from registers.
- Stage-0 next state, in priority order:
  - invalidate: 0.
  - kill_en with kill_stage==0: 0.
  - reload: 1 (sticky; stays 1 until cleared).
  - otherwise: hold.
  - reload is accepted even while instr_wait=1.
- Stage i>=1 next state:
  - invalidate: 0.
  - else if kill_en && i>=kill_stage: 0. This also drops whatever would have shifted into stage kill_stage that cycle.
  - else if instr_wait: hold.
  - else: stage_reached[i-1].
- Tags:
  - tag[0] <= reload_thread on an accepted reload.
  - tag[i] <= tag[i-1] whenever stage i advances (not invalidate, not killed, not instr_wait).
  - Tags are never cleared except by reset; they are meaningful only where reached=1.
- stage_allow[i] (registered) = ~invalidate & ~instr_wait & ~(kill_en & i>=kill_stage) & src, where src = reload|stage_reached[0] for i==0 and stage_reached[i-1] for i>=1.
  - Latency: reload at edge k gives stage_allow[0]=1 after edge k+1, stage_allow[i]=1 after edge k+1+i (no stalls).
- thread_almost_switched <= stage_reached[SWITCH_STAGE] & ~stage_reached[SWITCH_STAGE+1].
  - One-cycle pulse per pipeline fill.
  - Re-asserts if a kill leaves this pattern.
- thread_busy[t] <= OR over i of (stage_reached[i] & tag[i]==t). Computed from current registers, so it lags by one edge.
- Simultaneous events:
  - invalidate dominates kill_en, reload and instr_wait.
  - kill_en dominates instr_wait for killed stages; unkilled stages still obey instr_wait.
  - A kill_stage value >= N_STAGES clears nothing.
  - reload with kill_stage==0 is discarded.
- Reset asserted mid-operation clears everything immediately. The first reload after deassertion behaves as from empty.

Decomposition:
- Package cpu_pipe_pkg:
  - default N_STAGES and N_THREADS (from sha512.vh constants);
  - TW and stage-index width as localparam functions;
  - stage encoding constants (FETCH=0, READ0=1, DECODE=2, EXEC=3).
- One natural sub-module, cpu_pipe_slot: a single stage's reached bit, tag register and allow register, generate-instantiated N_STAGES times. Slot 0 uses its reload variant.

Test Plan (N_STAGES=4, N_THREADS=16, SWITCH_STAGE=1):
- Fill: reload=1, reload_thread=5 at edge 0 -> stage_allow sequence 0001, 0011, 0111, 1111 after edges 1..4; stage_thread all =5; thread_almost_switched=1 only after edge 3; thread_busy=0x0020 from edge 2; pipe_empty=0 after edge 1.
- Stall: full pipeline, instr_wait=1 for 3 cycles -> stage_allow=0000 during stall, reached and tags unchanged; resumes at 1111 one edge after release.
- Kill: full pipeline, kill_en=1, kill_stage=2 for one cycle -> stages 2,3 cleared, stage_allow=0011 that edge; refills to 1111 two edges later; thread_almost_switched pulses again.
- Invalidate+reload same cycle: invalidate=1, reload=1, reload_thread=9 -> all reached=0, pipe_empty=1, stage_allow=0000, tag[0] not changed to 9.
- Thread switch: thread 3 full, invalidate then reload thread 7 -> stage_thread[0]=7; thread_busy goes 0x0008 -> 0x0000 -> 0x0080.
- Async reset mid-fill: drop RESETn between edges -> outputs go to reset values without waiting for CLK; a reload after release fills exactly as in the Fill scenario.
